// File: rtl/prio_grant_arb.sv
`default_nettype none
// ============================================================================
// Module   : prio_grant_arb
// Brief    : Registered N-way arbiter with fixed-priority or round-robin
//            selection, presenting index and one-hot grant behind a
//            valid/ready handshake. The grant is sticky until accepted.
// Revision : 1.0 - initial release
// ============================================================================
module prio_grant_arb #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         gnt_ready,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] rr_ptr
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           r_gnt_valid;
  logic [W-1:0]   r_gnt_idx;
  logic [N-1:0]   r_gnt_onehot;
  logic [W-1:0]   r_rr_ptr;

  logic           w_valid_nxt;
  logic [W-1:0]   w_idx_nxt;
  logic [N-1:0]   w_onehot_nxt;
  logic [W-1:0]   w_ptr_nxt;

  logic           w_accept;
  logic           w_decide;
  logic           w_any;
  logic [W-1:0]   w_idx_inc;
  logic [W-1:0]   w_base;
  logic [N-1:0]   w_rot;
  logic [W-1:0]   w_rr_off;
  logic [W:0]     w_rr_sum;
  logic [W-1:0]   w_rr_win;
  logic [W-1:0]   w_fp_win;
  logic [W-1:0]   w_win;
  logic [N-1:0]   w_win_onehot;

  assign w_accept  = r_gnt_valid & gnt_ready;
  assign w_decide  = (r_state == S_IDLE) | w_accept;
  assign w_any     = |req;

  // Successor of the served line, wrapping explicitly so non-power-of-two N works.
  assign w_idx_inc = (r_gnt_idx == W'(N - 1)) ? '0 : r_gnt_idx + W'(1);

  // On a round-robin accept the just-served line becomes lowest priority at once.
  assign w_base    = (w_accept && mode) ? w_idx_inc : r_rr_ptr;

  // Rotate requests so bit 0 corresponds to the search base.
  assign w_rot     = N'({req, req} >> w_base);

  // Fixed priority: highest set index wins (later iterations override).
  always_comb begin
    w_fp_win = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) w_fp_win = W'(i);
    end
  end

  // Round-robin: lowest set bit of the rotated vector is the offset from base.
  always_comb begin
    w_rr_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_rr_off = W'(i);
    end
  end

  // Map the rotated offset back to an absolute index, wrapping at N.
  always_comb begin
    w_rr_sum = {1'b0, w_base} + {1'b0, w_rr_off};
    if (w_rr_sum >= (W + 1)'(N)) w_rr_sum = w_rr_sum - (W + 1)'(N);
    w_rr_win = w_rr_sum[W-1:0];
  end

  assign w_win        = mode ? w_rr_win : w_fp_win;
  assign w_win_onehot = {{(N - 1){1'b0}}, 1'b1} << w_win;

  // Next-state and next-output selection; everything holds unless a decision is made.
  always_comb begin
    w_state_nxt  = r_state;
    w_valid_nxt  = r_gnt_valid;
    w_idx_nxt    = r_gnt_idx;
    w_onehot_nxt = r_gnt_onehot;
    w_ptr_nxt    = r_rr_ptr;

    if (w_accept && mode) w_ptr_nxt = w_idx_inc;

    case (r_state)
      S_IDLE, S_HOLD: begin
        if (w_decide) begin
          if (w_any) begin
            w_state_nxt  = S_HOLD;
            w_valid_nxt  = 1'b1;
            w_idx_nxt    = w_win;
            w_onehot_nxt = w_win_onehot;
          end else begin
            w_state_nxt  = S_IDLE;
            w_valid_nxt  = 1'b0;
            w_idx_nxt    = '0;
            w_onehot_nxt = '0;
          end
        end
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_valid_nxt  = 1'b0;
        w_idx_nxt    = '0;
        w_onehot_nxt = '0;
      end
    endcase
  end

  // State and output registers; reset drops any held grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_gnt_valid  <= 1'b0;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_gnt_valid  <= w_valid_nxt;
      r_gnt_idx    <= w_idx_nxt;
      r_gnt_onehot <= w_onehot_nxt;
      r_rr_ptr     <= w_ptr_nxt;
    end
  end

  assign gnt_valid  = r_gnt_valid;
  assign gnt_idx    = r_gnt_idx;
  assign gnt_onehot = r_gnt_onehot;
  assign rr_ptr     = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_prio_grant_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_grant_arb
// Brief    : Scoreboard bench for prio_grant_arb with N=8 and N=5 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_grant_arb;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n8, mode8, rdy8, gv8;
  logic [7:0] req8, go8;
  logic [2:0] gi8, gp8;
  logic       rst_n5, mode5, rdy5, gv5;
  logic [4:0] req5, go5;
  logic [2:0] gi5, gp5;

  prio_grant_arb #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n8), .req(req8), .mode(mode8), .gnt_ready(rdy8),
    .gnt_valid(gv8), .gnt_idx(gi8), .gnt_onehot(go8), .rr_ptr(gp8)
  );

  prio_grant_arb #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n5), .req(req5), .mode(mode5), .gnt_ready(rdy5),
    .gnt_valid(gv5), .gnt_idx(gi5), .gnt_onehot(go5), .rr_ptr(gp5)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q8[$];
  logic [31:0] q5[$];
  int          mv[2];
  int          mi[2];
  int          mp[2];

  function automatic int pick(input logic [7:0] r, input logic m, input int b, input int n);
    int  w;
    int  j;
    bit  found;
    w = 0;
    found = 1'b0;
    if (!m) begin
      for (int i = 0; i < n; i++) if (r[i]) w = i;
    end else begin
      for (int k = 0; k < n; k++) begin
        j = (b + k) % n;
        if (!found && r[j]) begin
          w = j;
          found = 1'b1;
        end
      end
    end
    return w;
  endfunction

  function automatic logic [31:0] act8();
    return {7'b0, gv8, 5'b0, gi8, go8, 5'b0, gp8};
  endfunction

  function automatic logic [31:0] act5();
    return {7'b0, gv5, 5'b0, gi5, 3'b0, go5, 5'b0, gp5};
  endfunction

  task automatic model_reset(input int d);
    mv[d] = 0;
    mi[d] = 0;
    mp[d] = 0;
    if (d == 0) q8.delete(); else q5.delete();
  endtask

  // Advance the reference model with the inputs as driven, push its
  // prediction, then let the DUT take the edge.
  task automatic drive_cycle(input int d);
    logic [7:0]  r;
    logic        m, rd, acc, dec;
    int          n, nb;
    logic [7:0]  oh;
    logic [31:0] e;
    if (d == 0) begin r = req8; m = mode8; rd = rdy8; n = 8; end
    else        begin r = {3'b0, req5}; m = mode5; rd = rdy5; n = 5; end
    acc = (mv[d] != 0) && rd;
    dec = (mv[d] == 0) || acc;
    nb  = (acc && m) ? (mi[d] + 1) % n : mp[d];
    mp[d] = nb;
    if (dec) begin
      if (r != 8'h00) begin mv[d] = 1; mi[d] = pick(r, m, nb, n); end
      else            begin mv[d] = 0; mi[d] = 0; end
    end
    oh = (mv[d] != 0) ? 8'(1 << mi[d]) : 8'h00;
    e  = {8'(mv[d]), 8'(mi[d]), oh, 8'(mp[d])};
    if (d == 0) q8.push_back(e); else q5.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    rst_n8 = 1'b0; rst_n5 = 1'b0;
    req8 = 8'hFF; mode8 = 1'b0; rdy8 = 1'b1;
    req5 = 5'h00; mode5 = 1'b0; rdy5 = 1'b1;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (act8() !== 32'h0) begin bad++; $display("FAIL reset8 got=%h want=%h", act8(), 32'h0); end
    total++;
    if (act5() !== 32'h0) begin bad++; $display("FAIL reset5 got=%h want=%h", act5(), 32'h0); end
    @(negedge clk);
    rst_n8 = 1'b1; rst_n5 = 1'b1; req8 = 8'h00;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0);
      e = q8.pop_front();
      total++;
      if (act8() !== e) begin bad++; $display("FAIL idle_after_reset got=%h want=%h", act8(), e); end
    end
  endtask

  task automatic test_fixed_sweep();
    logic [31:0] e;
    mode8 = 1'b0; rdy8 = 1'b1;
    for (int v = 0; v < 256; v++) begin
      req8 = 8'(v);
      drive_cycle(0);
      e = q8.pop_front();
      total++;
      if (act8() !== e) begin bad++; $display("FAIL fixed_sweep req=%h got=%h want=%h", req8, act8(), e); end
      if (v == 8'h2C) begin
        total++;
        if (gi8 !== 3'd5 || go8 !== 8'h20)
          begin bad++; $display("FAIL fixed_example idx=%0d oh=%h want idx=5 oh=20", gi8, go8); end
      end
    end
  endtask

  task automatic test_rr_fair();
    logic [31:0] e;
    mode8 = 1'b1; rdy8 = 1'b1; req8 = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      drive_cycle(0);
      e = q8.pop_front();
      total++;
      if (act8() !== e) begin bad++; $display("FAIL rr_fair_sb got=%h want=%h", act8(), e); end
      total++;
      if (gi8 !== 3'(k % 8) || gp8 !== 3'(k % 8) || gv8 !== 1'b1)
        begin bad++; $display("FAIL rr_fair_seq k=%0d idx=%0d ptr=%0d want %0d", k, gi8, gp8, k % 8); end
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] e;
    mode8 = 1'b0; rdy8 = 1'b1; req8 = 8'h08;
    drive_cycle(0);
    e = q8.pop_front();
    total++;
    if (act8() !== e || gi8 !== 3'd3) begin bad++; $display("FAIL bp_grant3 got=%h want=%h", act8(), e); end
    rdy8 = 1'b0; req8 = 8'h80;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(0);
      e = q8.pop_front();
      total++;
      if (act8() !== e || gi8 !== 3'd3 || gv8 !== 1'b1)
        begin bad++; $display("FAIL bp_sticky got=%h want=%h", act8(), e); end
    end
    rdy8 = 1'b1;
    drive_cycle(0);
    e = q8.pop_front();
    total++;
    if (act8() !== e || gi8 !== 3'd7) begin bad++; $display("FAIL bp_release got=%h want=%h", act8(), e); end
  endtask

  task automatic test_sparse_rr();
    logic [31:0] e;
    logic [7:0]  rq[6];
    logic [2:0]  xi[6];
    logic [2:0]  xp[6];
    rq = '{8'h20, 8'h05, 8'h05, 8'h05, 8'h80, 8'h01};
    xi = '{3'd5,  3'd0,  3'd2,  3'd0,  3'd7,  3'd0};
    xp = '{3'd0,  3'd6,  3'd1,  3'd3,  3'd1,  3'd0};
    mode8 = 1'b1; rdy8 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req8 = rq[k];
      drive_cycle(0);
      e = q8.pop_front();
      total++;
      if (act8() !== e || gi8 !== xi[k] || gp8 !== xp[k])
        begin bad++; $display("FAIL sparse_rr k=%0d got=%h want=%h idx=%0d ptr=%0d", k, act8(), e, xi[k], xp[k]); end
    end
    req8 = 8'h00;
    drive_cycle(0);
    e = q8.pop_front();
    total++;
    if (act8() !== e || gv8 !== 1'b0 || go8 !== 8'h00 || gi8 !== 3'd0)
      begin bad++; $display("FAIL accept_empty got=%h want=%h", act8(), e); end
  endtask

  task automatic test_n5_async_reset();
    logic [31:0] e;
    mode5 = 1'b1; rdy5 = 1'b1; req5 = 5'h1F;
    for (int k = 0; k < 7; k++) begin
      drive_cycle(1);
      e = q5.pop_front();
      total++;
      if (act5() !== e || gi5 !== 3'(k % 5))
        begin bad++; $display("FAIL n5_rr k=%0d got=%h want=%h", k, act5(), e); end
    end
    rdy5 = 1'b0;
    drive_cycle(1);
    e = q5.pop_front();
    total++;
    if (act5() !== e || gi5 !== 3'd1) begin bad++; $display("FAIL n5_hold got=%h want=%h", act5(), e); end
    rst_n5 = 1'b0;
    #1;
    total++;
    if (act5() !== 32'h0) begin bad++; $display("FAIL n5_async_clear got=%h want=%h", act5(), 32'h0); end
    model_reset(1);
    @(negedge clk);
    rst_n5 = 1'b1; rdy5 = 1'b1;
    drive_cycle(1);
    e = q5.pop_front();
    total++;
    if (act5() !== e || gi5 !== 3'd0 || gv5 !== 1'b1)
      begin bad++; $display("FAIL n5_post_reset got=%h want=%h", act5(), e); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fixed_sweep();
    test_rr_fair();
    test_back_pressure();
    test_sparse_rr();
    test_n5_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/prio_grant_arb.md
# prio_grant_arb

Parametrised, registered priority arbiter and encoder. It takes `N` level requests, picks one winner by fixed-priority or round-robin rule, and presents the winner's index and one-hot grant behind a valid/ready handshake. It sits between a bank of requesters and a single shared consumer. It replaces bare combinational N:log2(N) priority encoding wherever fairness, back-pressure or registered outputs are needed.

## Interface
- `N`, 8: number of request lines; any integer >= 2, power of two not required.
- `W`, `$clog2(N)`: index width; derived, not overridden.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Assertion clears all state immediately; deassertion is synchronous to `clk` externally.
- `req` input N: level request per line; bit N-1 is highest fixed priority.
- `mode` input 1: 0 = fixed priority (highest index wins), 1 = round-robin.
- `gnt_ready` input 1: consumer accepts the current grant when high with `gnt_valid`.
- `gnt_valid` output 1: registered; a grant is held on the outputs.
- `gnt_idx` output W: registered winner index.
- `gnt_onehot` output N: registered; equals `1 << gnt_idx` while valid, else 0.
- `rr_ptr` output W: registered round-robin search base, for debug and verification.

## Operation
- Two states:
  - IDLE: no grant held.
  - HOLD: grant held, waiting for accept.
- Accept = `gnt_valid && gnt_ready`.
- Decision point: any rising edge in IDLE, or an accept edge in HOLD.
  - At a decision point with `req != 0`: register the winner, enter or stay in HOLD.
  - At a decision point with `req == 0`: go to or stay in IDLE, with outputs cleared.
- Winner rule, using `mode` and `req` sampled at the decision edge:
  - mode 0: highest set index of `req`.
  - mode 1: first set index found searching upward from base `b` with wrap (b, b+1, ..., N-1, 0, ..., b-1).
- Search base `b` equals `rr_ptr`, except at an accept edge in mode 1, where `b = (gnt_idx+1) mod N`. The just-served line is therefore lowest priority in the same-cycle re-decision.
- `rr_ptr` update: on every accept with `mode == 1`, `rr_ptr <= (gnt_idx+1) mod N`. Wrap means index N-1 leads to 0, including for non-power-of-two N. No update in mode 0.
- Grant is sticky. While in HOLD without accept, `gnt_idx`, `gnt_onehot` and `gnt_valid` stay constant even if `req` changes or the granted bit drops. No retraction.
- Changing `mode` while in HOLD has no effect until the next decision point.
- No requester is ever granted an index >= N.

## Timing
- Reset values while `rst_n` is low:
  - state IDLE
  - `gnt_valid` = 0, `gnt_idx` = 0, `gnt_onehot` = 0, `rr_ptr` = 0.
- Latency: a request present at edge k in IDLE gives `gnt_valid` = 1 after edge k, visible in cycle k+1.
- Throughput: with `gnt_ready` held high and `req != 0`, one grant per cycle; `gnt_valid` stays high continuously.
- Back-pressure: `gnt_ready` low holds all outputs indefinitely.
- Accept with `req == 0`: `gnt_valid` falls after that edge, and `gnt_onehot` and `gnt_idx` are cleared.
- Reset asserted mid-HOLD: grant is dropped immediately, with no accept and no `rr_ptr` update. First grant after reset uses base 0.
- All outputs are purely registered; no combinational path from inputs to outputs.

## Test plan
- Reset and idle: hold `rst_n` = 0 and drive `req` = 8'hFF. Required: `gnt_valid` = 0, `gnt_onehot` = 0, `rr_ptr` = 0. Release with `req` = 0: outputs stay 0.
- Fixed priority sweep (N=8, mode 0, `gnt_ready` = 1): drive `req` = 0..255 one per cycle. Required: one cycle later, `gnt_idx` equals the highest set bit and `gnt_valid` = (req != 0). Example: 8'b0010_1100 gives idx 5 and onehot 8'h20.
- Round-robin fairness (mode 1, `req` = 8'hFF, ready = 1): required grant sequence 0,1,2,...,7,0 on consecutive cycles, with `rr_ptr` following idx+1 and wrapping 7 to 0.
- Back-pressure and stickiness: grant idx 3 with ready = 0, then change `req` to 8'h80 for 5 cycles. Required: idx stays 3 and valid stays 1. Raise ready: next grant is 7.
- Sparse round-robin with wrap: `rr_ptr` = 6 and `req` = 8'b0000_0101 in mode 1. Required grants 0, 2, 0, ..., and accepting idx 7 with `req` = 8'h01 yields `rr_ptr` = 0 and grant 0.
- Non-power-of-two N=5 plus async reset: `req` = 5'h1F in mode 1 gives 0,1,2,3,4,0. Pulsing `rst_n` low mid-HOLD clears outputs at once, and the next grant is 0.
